aes_128_sched: RTL and testbench
================================

AES_128_SCHED -- requirements
Module: aes_128_sched

Interface
REQ-001 Parameter CORE_LAT, default 21: cycles from core input sample to core result valid; SHALL equal the wrapped aes_128 core's latency.
REQ-002 Parameter TAG_W, default 4: width of per-request tag.
REQ-003 clk  input  1  sole clock, all state on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester n has a block to encrypt.
REQ-006 req0_ready / req1_ready  output  1  grant; transfer occurs when valid && ready.
REQ-007 req0_state, req0_key / req1_state, req1_key  input  128  plaintext and key.
REQ-008 req0_tag / req1_tag  input  TAG_W  opaque id returned with result.
REQ-009 rsp0_valid / rsp1_valid  output  1  one-cycle pulse, ciphertext for requester n.
REQ-010 rsp_data  output  128  ciphertext, shared by both response ports.
REQ-011 rsp_tag  output  TAG_W  tag of the request producing rsp_data.
REQ-012 busy  output  1  high while any issued request is still in flight.

Function
REQ-013 Core is fully pipelined and never stalls; at most one request SHALL be issued per cycle.
REQ-014 Arbitration SHALL be combinational from valids and a registered last_grant bit: only one valid -> grant it; both valid -> grant the requester not granted last; none -> no grant.
REQ-015 last_grant SHALL update only on a completed transfer.
REQ-016 At most one of req0_ready/req1_ready SHALL be high in any cycle; ready SHALL never be high with the matching valid low.
REQ-017 On transfer, the granted state/key SHALL drive the core; on idle cycles core inputs SHALL be held at zero.
REQ-018 A CORE_LAT-deep tracking shift register SHALL carry {valid, requester id, tag} alongside each issued block.
REQ-019 When the tracking entry exits with valid=1, the matching rspN_valid SHALL pulse for exactly one cycle with rsp_data = core output and rsp_tag = stored tag; latency issue->response SHALL be exactly CORE_LAT cycles.
REQ-020 Responses SHALL NOT be backpressured; requesters SHALL accept any response pulse.
REQ-021 Responses SHALL return in issue order; back-to-back issues SHALL yield back-to-back responses.
REQ-022 busy SHALL equal the OR of all tracking valid bits.
REQ-023 rsp_data/rsp_tag SHALL be don't-care when neither rspN_valid is high.

Reset
REQ-024 On rst assertion all tracking valid bits, last_grant (=1, so requester 0 wins first contention), rsp0_valid, rsp1_valid, busy SHALL clear immediately.
REQ-025 Requests in flight at reset SHALL be discarded; no response pulse SHALL ever appear for them.
REQ-026 The core datapath carries no reset; its garbage output SHALL be masked by the tracking valid bits.
REQ-027 req0_ready/req1_ready SHALL be low while rst is high.

Configuration
REQ-028 Macro AES_SCHED_STATS_EN defined: SHALL add outputs issue_cnt0, issue_cnt1 (32 bits each), incremented on each transfer of that requester, cleared by rst, wrapping at 2^32-1 -> 0.
REQ-029 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package aes_sched_pkg SHALL hold CORE_LAT default, requester-id type (1 bit), and the tracking-entry struct {valid, id, tag}.
REQ-031 One sub-module: aes_128 core instantiated once; arbitration and tracking remain in aes_128_sched.

Verification
REQ-032 Single request: req0 valid, key 000102..0f, state 00112233..eeff, tag 3 -> after 21 cycles rsp0_valid one pulse, rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_tag 3.
REQ-033 Contention: both valid continuously for 8 cycles after reset -> grants alternate 0,1,0,1...; responses alternate rsp0/rsp1 on 8 consecutive cycles with matching tags.
REQ-034 One-sided: only req1 valid for 5 cycles -> req1_ready high all 5 cycles; 5 consecutive rsp1 pulses; rsp0_valid never high.
REQ-035 Reset mid-flight: issue 3 requests, assert rst 10 cycles later for 2 cycles -> busy drops immediately; no response pulses ever for those 3.
REQ-036 Idle gaps: issues at cycles 0, 2, 7 -> responses exactly at cycles 21, 23, 28; busy low from cycle 29.
REQ-037 With AES_SCHED_STATS_EN: 6 transfers from req0 and 4 from req1 -> issue_cnt0=6, issue_cnt1=4; rst returns both to 0.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// rtl/aes_sched_pkg.sv - shared types and defaults for the AES-128 request scheduler
package aes_sched_pkg;

  localparam int CORE_LAT_DEF = 21;
  // Tag field is sized for the widest supported TAG_W; narrower tags are zero-extended.
  localparam int TAG_W_MAX    = 16;

  typedef logic req_id_t;

  typedef struct packed {
    logic                 valid;
    req_id_t              id;
    logic [TAG_W_MAX-1:0] tag;
  } track_t;

endpackage

// File: rtl/aes_128.sv
// rtl/aes_128.sv - fully pipelined AES-128 encryption core, 21-cycle latency, no reset on datapath
module aes_128 (
  input  logic         clk_i,
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  output logic [127:0] state_o
);

  localparam int STAGES = 21;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box built as GF(2^8) inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input int round);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < round; i++) rc = xtime(rc);
    return rc;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [127:0] st_q  [STAGES];
  logic [127:0] key_q [STAGES-1];

  // Each round spans two stages: SubBytes/ShiftRows + key expansion, then MixColumns/AddRoundKey.
  always_ff @(posedge clk_i) begin
    st_q[0]  <= state_i ^ key_i;
    key_q[0] <= key_i;
    for (int r = 1; r <= 9; r++) begin
      st_q[2*r-1]  <= sub_shift(st_q[2*r-2]);
      key_q[2*r-1] <= next_key(key_q[2*r-2], rcon(r));
      st_q[2*r]    <= mix_columns(st_q[2*r-1]) ^ key_q[2*r-1];
      key_q[2*r]   <= key_q[2*r-1];
    end
    st_q[19]  <= sub_shift(st_q[18]);
    key_q[19] <= next_key(key_q[18], rcon(10));
    st_q[20]  <= st_q[19] ^ key_q[19];
  end

  assign state_o = st_q[STAGES-1];

endmodule

// File: rtl/aes_128_sched.sv
// rtl/aes_128_sched.sv - two-requester round-robin front end for a pipelined AES-128 core
// Optional per-requester issue counters when AES_SCHED_STATS_EN is defined.
module aes_128_sched
  import aes_sched_pkg::*;
#(
  parameter int CORE_LAT = CORE_LAT_DEF,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [127:0]     req0_state,
  input  logic [127:0]     req0_key,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [127:0]     req1_state,
  input  logic [127:0]     req1_key,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [127:0]     rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
`ifdef AES_SCHED_STATS_EN
  ,
  output logic [31:0]      issue_cnt0,
  output logic [31:0]      issue_cnt1
`endif
);

  logic         gnt0, gnt1, xfer;
  logic         last_grant_q;
  logic [127:0] core_state, core_key, core_out;
  track_t       trk_d;
  track_t       trk_q [CORE_LAT];
  logic         busy_d;

  // Ready is forced low during reset so nothing is accepted into a pipeline being flushed.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0_valid && (!req1_valid || last_grant_q)) gnt0 = 1'b1;
      else if (req1_valid)                             gnt1 = 1'b1;
    end
  end

  assign xfer       = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    core_state = '0;
    core_key   = '0;
    trk_d      = '0;
    if (gnt0) begin
      core_state = req0_state;
      core_key   = req0_key;
      trk_d.tag  = TAG_W_MAX'(req0_tag);
    end else if (gnt1) begin
      core_state = req1_state;
      core_key   = req1_key;
      trk_d.tag  = TAG_W_MAX'(req1_tag);
    end
    trk_d.valid = xfer;
    trk_d.id    = gnt1;
  end

  aes_128 u_core (
    .clk_i   (clk),
    .state_i (core_state),
    .key_i   (core_key),
    .state_o (core_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      for (int i = 0; i < CORE_LAT; i++) trk_q[i] <= '0;
    end else begin
      if (xfer) last_grant_q <= gnt1;
      trk_q[0] <= trk_d;
      for (int i = 1; i < CORE_LAT; i++) trk_q[i] <= trk_q[i-1];
    end
  end

  always_comb begin
    busy_d = 1'b0;
    for (int i = 0; i < CORE_LAT; i++) busy_d = busy_d | trk_q[i].valid;
  end

  assign busy       = busy_d;
  assign rsp0_valid = trk_q[CORE_LAT-1].valid && (trk_q[CORE_LAT-1].id == 1'b0);
  assign rsp1_valid = trk_q[CORE_LAT-1].valid && (trk_q[CORE_LAT-1].id == 1'b1);
  assign rsp_data   = core_out;
  assign rsp_tag    = trk_q[CORE_LAT-1].tag[TAG_W-1:0];

`ifdef AES_SCHED_STATS_EN
  logic [31:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt0) cnt0_q <= cnt0_q + 32'd1;
      if (gnt1) cnt1_q <= cnt1_q + 32'd1;
    end
  end

  assign issue_cnt0 = cnt0_q;
  assign issue_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_aes_128_sched.sv
// tb/tb_aes_128_sched.sv - scoreboard bench for aes_128_sched (AES_SCHED_STATS_EN optional)
module tb_aes_128_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_state, req0_key, req1_state, req1_key;
  logic [3:0]   req0_tag, req1_tag;
  logic         rsp0_valid, rsp1_valid;
  logic [127:0] rsp_data;
  logic [3:0]   rsp_tag;
  logic         busy;
`ifdef AES_SCHED_STATS_EN
  logic [31:0]  issue_cnt0, issue_cnt1;
`endif

  always #5 clk = ~clk;

  aes_128_sched #(.CORE_LAT(21), .TAG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_state (req0_state),
    .req0_key   (req0_key),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_state (req1_state),
    .req1_key   (req1_key),
    .req1_tag   (req1_tag),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .busy       (busy)
`ifdef AES_SCHED_STATS_EN
    ,
    .issue_cnt0 (issue_cnt0),
    .issue_cnt1 (issue_cnt1)
`endif
  );

  typedef struct {
    int           due;
    logic         port;
    logic [127:0] data;
    logic [3:0]   tag;
  } exp_t;

  exp_t         sb[$];
  exp_t         me;
  logic         bexp;
  logic         last_m;
  int           n0_m, n1_m;
  int           tests = 0;
  int           fails = 0;
  int           cyc   = 0;
  logic [127:0] vk [7];
  logic [127:0] vp [7];
  logic [127:0] vc [7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of requests, check grants against the round-robin model, log transfers.
  task automatic step(input logic v0, input logic v1, input int i0, input int i1,
                      input logic [3:0] t0, input logic [3:0] t1);
    logic g0, g1;
    exp_t e;
    @(posedge clk);
    #1;
    req0_valid = v0;  req0_state = vp[i0];  req0_key = vk[i0];  req0_tag = t0;
    req1_valid = v1;  req1_state = vp[i1];  req1_key = vk[i1];  req1_tag = t1;
    #2;
    g0 = !rst && v0 && (!v1 || last_m);
    g1 = !rst && v1 && (!v0 || !last_m);
    chk1("req0_ready", req0_ready, g0);
    chk1("req1_ready", req1_ready, g1);
    if (g0 || g1) begin
      e.due  = cyc + 21;
      e.port = g1;
      e.data = g1 ? vc[i1] : vc[i0];
      e.tag  = g1 ? t1 : t0;
      sb.push_back(e);
      last_m = g1;
      if (g1) n1_m++;
      else    n0_m++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0, 0, 4'd0, 4'd0);
  endtask

  task automatic do_reset();
`ifdef AES_SCHED_STATS_EN
    chk("issue_cnt0_pre", 128'(issue_cnt0), 128'(n0_m));
    chk("issue_cnt1_pre", 128'(issue_cnt1), 128'(n1_m));
`endif
    @(posedge clk);
    #1;
    rst        = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    sb.delete();
    last_m = 1'b1;
    n0_m   = 0;
    n1_m   = 0;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rsp0", rsp0_valid, 1'b0);
    chk1("rst_rsp1", rsp1_valid, 1'b0);
    chk1("rst_ready0", req0_ready, 1'b0);
    chk1("rst_ready1", req1_ready, 1'b0);
`ifdef AES_SCHED_STATS_EN
    chk("issue_cnt0_rst", 128'(issue_cnt0), 128'd0);
    chk("issue_cnt1_rst", 128'(issue_cnt1), 128'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst        = 1'b0;
  endtask

  // Monitor: every response pulse must match the oldest outstanding entry, on its due cycle.
  initial begin
    forever begin
      @(posedge clk);
      #4;
      bexp = (sb.size() > 0) && (sb[0].due - 21 < cyc);
      chk1("busy", busy, bexp);
      chk1("rsp_onehot", rsp0_valid & rsp1_valid, 1'b0);
      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) begin
          chk1("rsp_unexpected", 1'b1, 1'b0);
        end else begin
          me = sb.pop_front();
          chk("rsp_cycle", 128'(cyc), 128'(me.due));
          chk1("rsp1_port", rsp1_valid, me.port);
          chk("rsp_data", rsp_data, me.data);
          chk("rsp_tag", 128'(rsp_tag), 128'(me.tag));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        me = sb.pop_front();
        chk1("rsp_missing", rsp0_valid | rsp1_valid, 1'b1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vk[0] = 128'h000102030405060708090a0b0c0d0e0f;
    vp[0] = 128'h00112233445566778899aabbccddeeff;
    vc[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    vk[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vp[1] = 128'h3243f6a8885a308d313198a2e0370734;
    vc[1] = 128'h3925841d02dc09fbdc118597196a0b32;
    vk[2] = 128'h0;
    vp[2] = 128'h0;
    vc[2] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    vk[3] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vp[3] = 128'h6bc1bee22e409f96e93d7e117393172a;
    vc[3] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    vk[4] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vp[4] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    vc[4] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    vk[5] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vp[5] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    vc[5] = 128'h43b1cd7f598ece23881b00e3ed030688;
    vk[6] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vp[6] = 128'hf69f2445df4f9b17ad2b417be66c3710;
    vc[6] = 128'h7b0c785e27e8ad3f8223207104725dd4;

    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_state = '0;  req0_key = '0;  req0_tag = '0;
    req1_state = '0;  req1_key = '0;  req1_tag = '0;
    last_m = 1'b1;
    n0_m   = 0;
    n1_m   = 0;
    repeat (2) @(posedge clk);
    #1;
    chk1("init_busy", busy, 1'b0);
    chk1("init_rsp0", rsp0_valid, 1'b0);
    chk1("init_rsp1", rsp1_valid, 1'b0);
    chk1("init_ready0", req0_ready, 1'b0);
    rst = 1'b0;

    // Single FIPS-197 block from requester 0.
    step(1'b1, 1'b0, 0, 0, 4'd3, 4'd0);
    idle(24);

    // Continuous contention right after reset: requester 0 wins first, then alternation.
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, k % 7, (k + 3) % 7, 4'(k), 4'(k + 8));
    idle(24);

    // Only requester 1 active.
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 0, (k + 2) % 7, 4'd0, 4'(k));
    idle(24);

    // Reset while three blocks are in flight: none may ever come back.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, k + 1, 0, 4'(k + 5), 4'd0);
    idle(9);
    do_reset();
    idle(30);

    // Issues with gaps at relative cycles 0, 2 and 7.
    step(1'b1, 1'b0, 4, 0, 4'd1, 4'd0);
    idle(1);
    step(1'b1, 1'b0, 5, 0, 4'd2, 4'd0);
    idle(4);
    step(1'b1, 1'b0, 6, 0, 4'd4, 4'd0);
    idle(25);

    // Mixed traffic bringing the totals to six from requester 0 and four from requester 1.
    for (int k = 0; k < 2; k++) step(1'b1, 1'b1, 3, 1, 4'(k + 9), 4'(k + 11));
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 0, 2 + k, 4'd0, 4'(k + 13));
    for (int k = 0; k < 2; k++) step(1'b1, 1'b0, 5 + k, 0, 4'(k + 6), 4'd0);
    idle(25);
    do_reset();
    idle(2);

    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
